// File: rtl/ddr_pkg.sv
// ddr_pkg: shared sequencer state encoding, address geometry and ram_addr composition helper
package ddr_pkg;
  localparam int LINE_W = 25;
  localparam int HALF_BIT = 4;
  localparam int ADDR_W = 30;
  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_WB_LO = 3'd1,
    SEQ_WB_HI = 3'd2,
    SEQ_RD_LO = 3'd3,
    SEQ_RD_HI = 3'd4,
    SEQ_RESP  = 3'd5
  } seq_state_e;
  function automatic logic [ADDR_W-1:0] ram_addr_f(input logic [LINE_W-1:0] line, input logic half);
    return {line, half, 4'b0000};
  endfunction
endpackage

// File: rtl/ddr_line_seq_if.sv
// ddr_line_seq_if: cache-line request/response bus plus the ddr_ctrl beat handshake
interface ddr_line_seq_if;
  import ddr_pkg::*;
  logic                req_valid;
  logic                req_ready;
  logic                req_wb;
  logic [LINE_W-1:0]   req_fill_line;
  logic [LINE_W-1:0]   req_wb_line;
  logic [255:0]        req_wb_data;
  logic                resp_valid;
  logic                resp_err;
  logic [255:0]        resp_data;
  logic                ram_en;
  logic                ram_write;
  logic [ADDR_W-1:0]   ram_addr;
  logic [255:0]        data_to_ram;
  logic                ram_rdy;
  logic [255:0]        block_out;
  modport master (
    output req_valid, req_wb, req_fill_line, req_wb_line, req_wb_data, ram_rdy, block_out,
    input  req_ready, resp_valid, resp_err, resp_data, ram_en, ram_write, ram_addr, data_to_ram
  );
  modport slave (
    input  req_valid, req_wb, req_fill_line, req_wb_line, req_wb_data, ram_rdy, block_out,
    output req_ready, resp_valid, resp_err, resp_data, ram_en, ram_write, ram_addr, data_to_ram
  );
endinterface

// File: rtl/ddr_beat_timer.sv
// ddr_beat_timer: per-state watchdog, cleared on state entry, counts while a beat is pending
module ddr_beat_timer #(
  parameter int TIMEOUT = 4096,
  parameter int W = 13
) (
  input  logic ui_clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : run ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge ui_clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = run & (cnt_q == W'(TIMEOUT - 1));
endmodule

// File: rtl/ddr_line_seq.sv
// ddr_line_seq: splits a line fill / write-back+fill into 128-bit beats toward ddr_ctrl
module ddr_line_seq
  import ddr_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input logic ui_clk,
  input logic rst,
  ddr_line_seq_if.slave bus
);
  localparam int TW = ($clog2(TIMEOUT) > 13) ? $clog2(TIMEOUT) : 13;
  seq_state_e state_q, state_d;
  logic first_q, first_d;
  logic [LINE_W-1:0] wb_line_q, wb_line_d, fill_line_q, fill_line_d;
  logic [255:0] data_to_ram_q, data_to_ram_d, resp_data_q, resp_data_d;
  logic resp_valid_q, resp_valid_d, resp_err_q, resp_err_d, req_ready_q, req_ready_d;
  logic ram_en_q, ram_en_d, ram_write_q, ram_write_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic beat, beat_d, wb_d, half_d, accept, done, expired;
  always_comb begin
    beat = state_q inside {SEQ_WB_LO, SEQ_WB_HI, SEQ_RD_LO, SEQ_RD_HI};
    accept = bus.req_valid & req_ready_q;
    // ram_rdy may still reflect the previous beat on the entry cycle
    done = beat & bus.ram_rdy & ~first_q;
    state_d = state_q == SEQ_RESP ? SEQ_IDLE
            : accept ? (bus.req_wb ? SEQ_WB_LO : SEQ_RD_LO)
            : done ? seq_state_e'(state_q + 3'd1)
            : expired ? SEQ_RESP : state_q;
    first_d = state_d != state_q;
    wb_line_d = accept ? bus.req_wb_line : wb_line_q;
    fill_line_d = accept ? bus.req_fill_line : fill_line_q;
    data_to_ram_d = accept ? bus.req_wb_data : data_to_ram_q;
    beat_d = state_d inside {SEQ_WB_LO, SEQ_WB_HI, SEQ_RD_LO, SEQ_RD_HI};
    wb_d = state_d inside {SEQ_WB_LO, SEQ_WB_HI};
    half_d = state_d inside {SEQ_WB_HI, SEQ_RD_HI};
    ram_en_d = beat_d;
    ram_write_d = wb_d;
    ram_addr_d = beat_d ? ram_addr_f(wb_d ? wb_line_d : fill_line_d, half_d) : ram_addr_q;
    resp_data_d = done && state_q == SEQ_RD_LO ? {resp_data_q[255:128], bus.block_out[127:0]}
                : done && state_q == SEQ_RD_HI ? {bus.block_out[255:128], resp_data_q[127:0]}
                : resp_data_q;
    resp_valid_d = state_d == SEQ_RESP;
    resp_err_d = state_d == SEQ_RESP && !done;
    req_ready_d = state_d == SEQ_IDLE;
  end
  always_ff @(posedge ui_clk or posedge rst)
    if (rst) begin
      state_q <= SEQ_IDLE;
      first_q <= 1'b0;
      wb_line_q <= '0;
      fill_line_q <= '0;
      data_to_ram_q <= '0;
      resp_data_q <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q <= 1'b0;
      req_ready_q <= 1'b0;
      ram_en_q <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      wb_line_q <= wb_line_d;
      fill_line_q <= fill_line_d;
      data_to_ram_q <= data_to_ram_d;
      resp_data_q <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q <= resp_err_d;
      req_ready_q <= req_ready_d;
      ram_en_q <= ram_en_d;
      ram_write_q <= ram_write_d;
      ram_addr_q <= ram_addr_d;
    end
  ddr_beat_timer #(.TIMEOUT(TIMEOUT), .W(TW)) u_timer (
    .ui_clk(ui_clk),
    .rst(rst),
    .clear(first_d),
    .run(beat),
    .expired(expired)
  );
  assign bus.req_ready = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err = resp_err_q;
  assign bus.resp_data = resp_data_q;
  assign bus.ram_en = ram_en_q;
  assign bus.ram_write = ram_write_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.data_to_ram = data_to_ram_q;
endmodule

// File: tb/tb_ddr_line_seq.sv
// tb_ddr_line_seq: directed vectors against a small ddr_ctrl/memory model
module tb_ddr_line_seq;
  logic ui_clk = 1'b0;
  logic rst = 1'b1;
  ddr_line_seq_if bus();
  ddr_line_seq #(.TIMEOUT(16)) dut (.ui_clk(ui_clk), .rst(rst), .bus(bus));
  always #5 ui_clk = ~ui_clk;
  int total = 0, bad = 0;
  int dly = 1;
  logic hold = 1'b0, stuck = 1'b0;
  int beat_cyc = 0;
  logic [30:0] prev_op = '0;
  logic [127:0] mem_lo [32], mem_hi [32];
  bit wr_lo [32], wr_hi [32];
  logic [30:0] ops [$];
  logic [4:0] li;
  function automatic logic [127:0] pat_lo(input int i);
    return {4{32'hA000_0000 + i}};
  endfunction
  function automatic logic [127:0] pat_hi(input int i);
    return {4{32'hB000_0000 + i}};
  endfunction
  always @(posedge ui_clk) begin
    beat_cyc <= ({bus.ram_write, bus.ram_addr} != prev_op) ? 1 : beat_cyc + 1;
    prev_op <= {bus.ram_write, bus.ram_addr};
    if (bus.ram_en && bus.ram_write && bus.ram_rdy) begin
      if (bus.ram_addr[4]) begin
        mem_hi[bus.ram_addr[9:5]] <= bus.data_to_ram[255:128];
        wr_hi[bus.ram_addr[9:5]] <= 1'b1;
      end else begin
        mem_lo[bus.ram_addr[9:5]] <= bus.data_to_ram[127:0];
        wr_lo[bus.ram_addr[9:5]] <= 1'b1;
      end
    end
  end
  always_comb begin
    li = bus.ram_addr[9:5];
    bus.block_out = {wr_hi[li] ? mem_hi[li] : pat_hi(32'(li)), wr_lo[li] ? mem_lo[li] : pat_lo(32'(li))};
    bus.ram_rdy = !stuck && (hold || (bus.ram_en && beat_cyc >= dly));
  end
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic run_req(input logic wb, input logic [24:0] wl, input logic [24:0] fl,
                         input logic [255:0] wd, output int lat);
    int n;
    ops.delete();
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge ui_clk);
      n++;
    end
    bus.req_wb = wb;
    bus.req_wb_line = wl;
    bus.req_fill_line = fl;
    bus.req_wb_data = wd;
    bus.req_valid = 1'b1;
    @(posedge ui_clk);
    #1 bus.req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge ui_clk);
      n++;
      if (bus.ram_en && (ops.size() == 0 || ops[$] != {bus.ram_write, bus.ram_addr}))
        ops.push_back({bus.ram_write, bus.ram_addr});
    end while (!bus.resp_valid && n < 300);
    lat = bus.resp_valid ? n + 1 : -1;
  endtask
  typedef struct {
    logic wb;
    logic [24:0] wl, fl;
    logic [255:0] wd;
    int dly;
    logic hold;
    logic [255:0] exp;
    int lat;
  } vec_t;
  vec_t v [6];
  localparam logic [255:0] WBD = {16{16'hA55A}};
  initial begin
    int lat;
    logic [30:0] eops [$];
    logic [255:0] prev;
    v[0] = '{1'b0, 25'h0,  25'h12, '0,  7, 1'b0, {pat_hi(18), pat_lo(18)}, 18};
    v[1] = '{1'b1, 25'h3,  25'h4,  WBD, 3, 1'b0, {pat_hi(4), pat_lo(4)},  18};
    v[2] = '{1'b0, 25'h0,  25'h3,  '0,  2, 1'b0, WBD,                      8};
    v[3] = '{1'b0, 25'h0,  25'h5,  '0,  1, 1'b1, {pat_hi(5), pat_lo(5)},   6};
    v[4] = '{1'b1, 25'h7,  25'h7,  256'h1, 1, 1'b1, 256'h1,               10};
    v[5] = '{1'b1, 25'h9,  25'hA,  {pat_hi(20), pat_lo(20)}, 1, 1'b0, {pat_hi(10), pat_lo(10)}, 10};
    bus.req_valid = 1'b0;
    bus.req_wb = 1'b0;
    bus.req_wb_line = '0;
    bus.req_fill_line = '0;
    bus.req_wb_data = '0;
    repeat (2) @(negedge ui_clk);
    chk("reset_req_ready", 256'(bus.req_ready), 256'(0));
    chk("reset_outs", {bus.resp_valid, bus.resp_err, bus.ram_en, bus.ram_write, bus.ram_addr}, '0);
    chk("reset_data_to_ram", bus.data_to_ram, '0);
    chk("reset_resp_data", bus.resp_data, '0);
    rst = 1'b0;
    @(negedge ui_clk);
    chk("idle_req_ready", 256'(bus.req_ready), 256'(1));
    for (int i = 0; i < 6; i++) begin
      dly = v[i].dly;
      hold = v[i].hold;
      run_req(v[i].wb, v[i].wl, v[i].fl, v[i].wd, lat);
      eops.delete();
      if (v[i].wb) begin
        eops.push_back({1'b1, v[i].wl, 5'h00});
        eops.push_back({1'b1, v[i].wl, 5'h10});
      end
      eops.push_back({1'b0, v[i].fl, 5'h00});
      eops.push_back({1'b0, v[i].fl, 5'h10});
      chk($sformatf("v%0d_latency", i), 256'(lat), 256'(v[i].lat));
      chk($sformatf("v%0d_data", i), bus.resp_data, v[i].exp);
      chk($sformatf("v%0d_err", i), 256'(bus.resp_err), 256'(0));
      chk($sformatf("v%0d_nbeats", i), 256'(ops.size()), 256'(eops.size()));
      for (int k = 0; k < eops.size() && k < ops.size(); k++)
        chk($sformatf("v%0d_beat%0d", i, k), 256'(ops[k]), 256'(eops[k]));
      @(negedge ui_clk);
      chk($sformatf("v%0d_pulse", i), 256'({bus.resp_valid, bus.req_ready}), 256'(2'b01));
    end
    hold = 1'b0;
    stuck = 1'b1;
    prev = bus.resp_data;
    run_req(1'b0, 25'h0, 25'h11, '0, lat);
    chk("to_latency", 256'(lat), 256'(18));
    chk("to_err", 256'(bus.resp_err), 256'(1));
    chk("to_data_held", bus.resp_data, prev);
    @(negedge ui_clk);
    chk("to_after", 256'({bus.resp_valid, bus.resp_err, bus.req_ready}), 256'(3'b001));
    stuck = 1'b0;
    dly = 7;
    bus.req_wb = 1'b1;
    bus.req_wb_line = 25'h13;
    bus.req_fill_line = 25'h14;
    bus.req_wb_data = WBD;
    bus.req_valid = 1'b1;
    @(posedge ui_clk);
    #1 bus.req_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!(bus.ram_en && bus.ram_write && bus.ram_addr[4]) && n < 100) begin
        @(negedge ui_clk);
        n++;
      end
      chk("rst_reached_wb_hi", 256'({bus.ram_en, bus.ram_write, bus.ram_addr}), 256'({2'b11, 25'h13, 5'h10}));
    end
    @(posedge ui_clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs", {bus.req_ready, bus.resp_valid, bus.resp_err, bus.ram_en, bus.ram_write, bus.ram_addr}, '0);
    chk("async_rst_data", {bus.data_to_ram ^ bus.resp_data, bus.data_to_ram | bus.resp_data}, '0);
    @(negedge ui_clk);
    rst = 1'b0;
    @(negedge ui_clk);
    run_req(1'b0, 25'h0, 25'h15, '0, lat);
    chk("post_rst_latency", 256'(lat), 256'(18));
    chk("post_rst_data", bus.resp_data, {pat_hi(21), pat_lo(21)});
    chk("post_rst_err", 256'(bus.resp_err), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ddr_line_seq.md
# ddr_line_seq

- Line-level sequencer directly upstream of `ddr_ctrl`, in the `ui_clk` domain.
- Accepts one cache-line request from the cache miss handler: either a fill, or a write-back of a dirty victim followed by a fill.
- Splits each 256-bit line into two 128-bit half-beats on `ram_addr[4]`, drives the `ram_en`/`ram_write`/`ram_addr`/`data_to_ram` handshake, assembles the returned line and reports it with a single-cycle response pulse.

## Interface
- `TIMEOUT`, default 4096: max cycles one half-beat may wait for `ram_rdy` before abort.
- `ui_clk` in 1: sole clock (MIG user clock).
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; transfer when `req_valid & req_ready`.
- `req_wb` in 1: 1 = write back `req_wb_line` before the fill.
- `req_fill_line` in 25: line index to fill; maps to `ram_addr[29:5]`.
- `req_wb_line` in 25: victim line index.
- `req_wb_data` in 256: victim data.
- `resp_valid` out 1: one-cycle pulse, request finished.
- `resp_err` out 1: valid with `resp_valid`; 1 = timeout abort.
- `resp_data` out 256: filled line; held until next `resp_valid`.
- `ram_en`, `ram_write` out 1: to `ddr_ctrl`.
- `ram_addr` out 30: to `ddr_ctrl`.
- `data_to_ram` out 256: to `ddr_ctrl`.
- `ram_rdy` in 1: from `ddr_ctrl`.
- `block_out` in 256: from `ddr_ctrl`.

## Operation
- States: IDLE, WB_LO, WB_HI, RD_LO, RD_HI, RESP.
- On accept in IDLE, latch both line indices, `req_wb_data` and `req_wb`. Next state is WB_LO if `req_wb`, else RD_LO.
- Each beat state drives registered outputs: `ram_en`=1; `ram_write`=1 in WB_*, 0 in RD_*; `ram_addr`={line, h, 4'b0000} with h=0 for *_LO and h=1 for *_HI; `data_to_ram`=latched victim line (whole 256 bits; `ddr_ctrl` picks the half).
- A beat completes when `ram_rdy`=1 in any cycle except the first cycle of that state. `ram_rdy` is combinational on our outputs, so the entry cycle may show stale readiness.
- Transitions on completion: WB_LO→WB_HI→RD_LO→RD_HI→RESP.
- RD_LO completion captures `block_out[127:0]` into `resp_data[127:0]`. RD_HI completion captures `block_out[255:128]` into `resp_data[255:128]`.
- RESP: `resp_valid`=1, `ram_en`=0, then IDLE.
- Consecutive beats always differ in `ram_addr[4]`, and each request starts on a LO beat after the previous HI beat. `ddr_ctrl`'s address/op-change detector therefore never suppresses a beat.
- Watchdog: a 13-bit (≥ clog2(TIMEOUT)) counter clears on every state entry and increments in beat states.
- On reaching `TIMEOUT-1` without completion: go to RESP with `resp_err`=1. `resp_data` is left partially updated.

## Timing
- Reset values: `req_ready`=0 asserted-in-reset, then 1 in IDLE. `resp_valid`=0, `resp_err`=0, `resp_data`=0, `ram_en`=0, `ram_write`=0, `ram_addr`=0, `data_to_ram`=0. State is IDLE.
- All outputs are registered; no combinational path from `ram_rdy` or `req_valid` to outputs.
- Accept edge → first beat outputs valid on the next cycle.
- Minimum beat length is 2 cycles. Minimum fill latency is 1 + 2×2 + 1 = 6 cycles (accept to `resp_valid`). Minimum write-back+fill latency is 10 cycles.
- `req_ready` is 0 from the accept edge through RESP. A new request can be accepted in the cycle after `resp_valid`.
- Consumer need not acknowledge `resp_valid`; the pulse is never stretched.
- `req_valid` while busy is ignored; no queuing.
- `req_wb_line` == `req_fill_line` is legal: the write completes before the read, and the read returns the written data.
- Reset mid-beat clears outputs immediately. `ddr_ctrl` may still be finishing a MIG transaction; the first post-reset request waits on `ram_rdy` as normal.

## Structure
- Shared package `ddr_pkg`:
  - state encoding constants (`SEQ_IDLE`…`SEQ_RESP`)
  - `HALF_BIT`=4
  - line-index width 25
  - the `ram_addr` composition helper, which is also used by any future `ddr_ctrl` rework
- Sub-module `ddr_beat_timer`: the watchdog counter with `clear`, `run` and `expired` ports. All else is inline.

## Test plan
- Fill only: accept `req_fill_line`=25'h12, `ddr_ctrl` model rdy after 7 cycles per beat → `ram_addr` 30'h240 then 30'h250 with `ram_write`=0. `resp_valid` after 1+8+8+1 cycles, `resp_data` = model's {hi,lo} halves, `resp_err`=0.
- Write-back+fill: `req_wb`=1, wb line 25'h3, data 256'hA5…5A, fill 25'h4 → four beats in order 30'h60/W, 30'h70/W, 30'h80/R, 30'h90/R. The model memory holds A5…5A at line 3.
- Stale-ready guard: model holds `ram_rdy`=1 continuously → each beat still lasts exactly 2 cycles, and the fill completes at minimum 6-cycle latency.
- Same line write/read: wb line = fill line = 25'h7, data 256'h1 → `resp_data`=256'h1.
- Timeout: TIMEOUT=16, `ram_rdy` stuck 0 → RESP 16 cycles into RD_LO, `resp_valid`=1, `resp_err`=1, then `req_ready`=1.
- Async reset asserted mid-WB_HI → all outputs 0 within the same cycle. A subsequent fill completes correctly.
